// File: rtl/eza_pkg.sv
// Shared constants and elaboration-time helpers for the edge zone averager.
// Zone tables are packed MSB-first: entry 0 occupies the lowest bit indices.
package eza_pkg;

  localparam int RGB_W  = 24;
  localparam int CH_W   = 8;
  // Upper bound on a zone table: 64 zones of up to 16-bit coordinates.
  localparam int ZT_MAX = 64 * 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int w_log2, input int h_log2);
    return CH_W + w_log2 + h_log2;
  endfunction

  // tbl is the table zero-padded on the left to ZT_MAX bits; entry i of n
  // entries of width w ends w*(n-1-i) bits above the numeric LSB.
  function automatic logic [15:0] zone_coord(input logic [0:ZT_MAX-1] tbl,
                                             input int i, input int w, input int n);
    return 16'(tbl >> (w * (n - 1 - i))) & ((16'd1 << w) - 16'd1);
  endfunction

endpackage

// File: rtl/eza_iir_ch.sv
// Single-channel temporal smoothing step: res + ((avg - res) >>> shift),
// or a straight copy of avg when smoothing is disabled.
module eza_iir_ch
  import eza_pkg::*;
(
  input  logic [CH_W-1:0] avg_i,
  input  logic [CH_W-1:0] res_i,
  input  logic [2:0]      shift_i,
  input  logic            en_i,
  output logic [CH_W-1:0] res_o
);

  logic signed [CH_W:0] diff;
  logic signed [CH_W:0] step;

  // The step never overshoots avg, so the 8-bit wrap-around sum is exact.
  always_comb begin
    diff  = $signed({1'b0, avg_i}) - $signed({1'b0, res_i});
    step  = diff >>> shift_i;
    res_o = en_i ? res_i + step[CH_W-1:0] : avg_i;
  end

endmodule

// File: rtl/edge_zone_averager.sv
// Per-zone R/G/B averaging over a pixel stream with optional IIR smoothing;
// results are published at each vsync rising edge and read through rd_idx.
module edge_zone_averager
  import eza_pkg::*;
#(
  parameter int                 NZ          = 60,
  parameter int                 XY_W        = 11,
  parameter int                 ZONE_W_LOG2 = 5,
  parameter int                 ZONE_H_LOG2 = 5,
  parameter logic [0:XY_W*NZ-1] ZX          = {NZ{11'd0}},
  parameter logic [0:XY_W*NZ-1] ZY          = {NZ{11'd0}},
  parameter int                 IDX_W       = 6
) (
  input  logic             clk_pixel,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_hsync,
  input  logic             pre_frame_de,
  input  logic [RGB_W-1:0] pre_rgb,
  input  logic             smooth_en,
  input  logic [2:0]       smooth_shift,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [RGB_W-1:0] rd_rgb,
  output logic             frame_done,
  output logic             frame_valid,
  output logic             post_frame_vsync,
  output logic             post_frame_hsync
);

  localparam int SH = ZONE_W_LOG2 + ZONE_H_LOG2;
  localparam int AW = acc_w(ZONE_W_LOG2, ZONE_H_LOG2);
  localparam logic [0:ZT_MAX-1] ZX_T = ZT_MAX'(ZX);
  localparam logic [0:ZT_MAX-1] ZY_T = ZT_MAX'(ZY);

  function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
    return (v == '1) ? v : v + XY_W'(1);
  endfunction

  function automatic logic [CH_W-1:0] avg_ch(input logic [AW-1:0] a);
    return CH_W'(a >> SH);
  endfunction

  logic [XY_W-1:0]  x_q, x_d, y_q, y_d;
  logic             vs_prev_q, de_prev_q, sync_ok_q, sync_ok_d;
  logic             vs_rise, frame_end, iir_en;
  logic [RGB_W-1:0] rgb_p1_q;
  logic             vld_p1_q;
  logic [XY_W-1:0]  x_p1_q, y_p1_q;
  logic             frame_done_q, frame_valid_q;
  logic [RGB_W-1:0] rd_rgb_q, rd_rgb_d;
  logic             vs_d1_q, vs_d2_q, hs_d1_q, hs_d2_q;
  logic [RGB_W-1:0] zone_res [NZ];

  assign vs_rise   = pre_frame_vsync & ~vs_prev_q;
  // Nothing is published until a full frame has been seen after reset.
  assign frame_end = vs_rise & sync_ok_q;
  assign iir_en    = smooth_en & frame_valid_q;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    sync_ok_d = sync_ok_q;
    if (vs_rise) begin
      x_d       = '0;
      y_d       = '0;
      sync_ok_d = 1'b1;
    end else if (pre_frame_de) begin
      x_d = sat_inc(x_q);
    end else if (de_prev_q) begin
      x_d = '0;
      y_d = sat_inc(y_q);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      sync_ok_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      vs_prev_q <= pre_frame_vsync;
      de_prev_q <= pre_frame_de;
      sync_ok_q <= sync_ok_d;
    end
  end

  // ---- stage 1: register pixel with its coordinates ----
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      rgb_p1_q <= '0;
      vld_p1_q <= 1'b0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
    end else begin
      rgb_p1_q <= pre_rgb;
      vld_p1_q <= pre_frame_de;
      x_p1_q   <= x_q;
      y_p1_q   <= y_q;
    end
  end

  // ---- stage 2: zone hit test, accumulate, publish at frame end ----
  for (genvar z = 0; z < NZ; z++) begin : g_zone
    localparam logic [XY_W:0] X_LO = {1'b0, XY_W'(zone_coord(ZX_T, z, XY_W, NZ))};
    localparam logic [XY_W:0] Y_LO = {1'b0, XY_W'(zone_coord(ZY_T, z, XY_W, NZ))};
    localparam logic [XY_W:0] X_HI = X_LO + (XY_W+1)'(1 << ZONE_W_LOG2);
    localparam logic [XY_W:0] Y_HI = Y_LO + (XY_W+1)'(1 << ZONE_H_LOG2);

    logic             hit;
    logic [AW-1:0]    acc_r_q, acc_g_q, acc_b_q;
    logic [CH_W-1:0]  nxt_r, nxt_g, nxt_b;
    logic [RGB_W-1:0] res_q;

    assign hit = vld_p1_q & sync_ok_q
               & ({1'b0, x_p1_q} >= X_LO) & ({1'b0, x_p1_q} < X_HI)
               & ({1'b0, y_p1_q} >= Y_LO) & ({1'b0, y_p1_q} < Y_HI);

    // A pixel landing in the frame-end cycle is dropped by the clear.
    always_ff @(posedge clk_pixel) begin
      if (rst || vs_rise) begin
        acc_r_q <= '0;
        acc_g_q <= '0;
        acc_b_q <= '0;
      end else if (hit) begin
        acc_r_q <= acc_r_q + AW'(rgb_p1_q[23:16]);
        acc_g_q <= acc_g_q + AW'(rgb_p1_q[15:8]);
        acc_b_q <= acc_b_q + AW'(rgb_p1_q[7:0]);
      end
    end

    eza_iir_ch u_iir_r (.avg_i(avg_ch(acc_r_q)), .res_i(res_q[23:16]),
                        .shift_i(smooth_shift), .en_i(iir_en), .res_o(nxt_r));
    eza_iir_ch u_iir_g (.avg_i(avg_ch(acc_g_q)), .res_i(res_q[15:8]),
                        .shift_i(smooth_shift), .en_i(iir_en), .res_o(nxt_g));
    eza_iir_ch u_iir_b (.avg_i(avg_ch(acc_b_q)), .res_i(res_q[7:0]),
                        .shift_i(smooth_shift), .en_i(iir_en), .res_o(nxt_b));

    always_ff @(posedge clk_pixel) begin
      if (rst) begin
        res_q <= '0;
      end else if (frame_end) begin
        res_q <= {nxt_r, nxt_g, nxt_b};
      end
    end

    assign zone_res[z] = res_q;
  end

  always_comb begin
    rd_rgb_d = '0;
    for (int z = 0; z < NZ; z++) begin
      if (rd_idx == IDX_W'(z)) rd_rgb_d = zone_res[z];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_rgb_q      <= '0;
      vs_d1_q       <= 1'b0;
      vs_d2_q       <= 1'b0;
      hs_d1_q       <= 1'b0;
      hs_d2_q       <= 1'b0;
    end else begin
      frame_done_q  <= frame_end;
      frame_valid_q <= frame_valid_q | frame_end;
      rd_rgb_q      <= rd_rgb_d;
      vs_d1_q       <= pre_frame_vsync;
      vs_d2_q       <= vs_d1_q;
      hs_d1_q       <= pre_frame_hsync;
      hs_d2_q       <= hs_d1_q;
    end
  end

  assign rd_rgb           = rd_rgb_q;
  assign frame_done       = frame_done_q;
  assign frame_valid      = frame_valid_q;
  assign post_frame_vsync = vs_d2_q;
  assign post_frame_hsync = hs_d2_q;

endmodule
